// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle data-memory target with valid/ready request and response channels.
// Latency: response valid in the cycle after edge N+WAIT_CYCLES for a request accepted at edge N.
// Backpressure: one transaction in flight; req_ready stays low until the response is taken.
// Optional: define DMEM_STATS_EN to add saturating load/store/error access counters.
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
`ifdef DMEM_STATS_EN
    ,
    output logic [15:0] stat_loads,
    output logic [15:0] stat_stores,
    output logic [15:0] stat_errs
`endif
);

    localparam int          IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] DEPTH_L = DEPTH_WORDS;
    localparam logic [3:0]  WAIT_L  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } req_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        cap_q, cap_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_err_q, resp_err_d;

    logic [31:0] mem [DEPTH_WORDS];

    // Access-edge controls and the request fields the access uses
    req_t             acc;
    logic             do_access;
    logic             acc_oor;
    logic             acc_err;
    logic [IDX_W-1:0] acc_idx;
    logic [31:0]      mem_rd;
    logic             mem_we;

    // Pick live request fields when accessing straight from IDLE, else the captured copy
    always_comb begin
        acc = cap_q;
        if (state_q == S_IDLE) begin
            acc = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
        end
        do_access = ((state_q == S_IDLE) && req_valid && (WAIT_CYCLES == 0)) ||
                    ((state_q == S_WAIT) && (cnt_q == 4'd1));
        acc_oor   = {2'b00, acc.addr[31:2]} >= DEPTH_L;
        acc_err   = (acc.addr[1:0] != 2'b00) || acc_oor;
        acc_idx   = acc.addr[IDX_W+1:2];
        mem_rd    = acc_oor ? 32'd0 : mem[acc_idx];
        mem_we    = do_access && acc.we && !acc_err && !reset;
    end

    // Storage: byte-lane writes, deliberately not reset so contents survive reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (mem_we && acc.be[i]) begin
                mem[acc_idx][8*i +: 8] <= acc.wdata[8*i +: 8];
            end
        end
    end

    // State, wait counter, captured request and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            cap_q        <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'd0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            cap_q        <= cap_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Next-state logic: IDLE accepts, WAIT counts down, RESP waits for the handshake
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cap_d   = cap_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    cap_d = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
                    if (WAIT_CYCLES == 0) begin
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = WAIT_L;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = S_RESP;
                    cnt_d   = 4'd0;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output logic: outputs are registered from the next state and the access result
    always_comb begin
        req_ready_d  = (state_d == S_IDLE);
        resp_valid_d = (state_d == S_RESP);
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        if (do_access) begin
            resp_err_d   = acc_err;
            resp_rdata_d = (!acc_err && !acc.we) ? mem_rd : 32'd0;
        end else if ((state_q == S_RESP) && resp_ready) begin
            resp_rdata_d = 32'd0;
            resp_err_d   = 1'b0;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;

`ifdef DMEM_STATS_EN
    logic [15:0] stat_loads_q, stat_loads_d;
    logic [15:0] stat_stores_q, stat_stores_d;
    logic [15:0] stat_errs_q, stat_errs_d;

    // Saturating access counters, bumped on the access edge
    always_comb begin
        stat_loads_d  = stat_loads_q;
        stat_stores_d = stat_stores_q;
        stat_errs_d   = stat_errs_q;
        if (do_access) begin
            if (acc_err) begin
                if (stat_errs_q != 16'hFFFF) stat_errs_d = stat_errs_q + 16'd1;
            end else if (acc.we) begin
                if (stat_stores_q != 16'hFFFF) stat_stores_d = stat_stores_q + 16'd1;
            end else begin
                if (stat_loads_q != 16'hFFFF) stat_loads_d = stat_loads_q + 16'd1;
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_loads_q  <= 16'd0;
            stat_stores_q <= 16'd0;
            stat_errs_q   <= 16'd0;
        end else begin
            stat_loads_q  <= stat_loads_d;
            stat_stores_q <= stat_stores_d;
            stat_errs_q   <= stat_errs_d;
        end
    end

    assign stat_loads  = stat_loads_q;
    assign stat_stores = stat_stores_q;
    assign stat_errs   = stat_errs_q;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: instance 0 uses WAIT_CYCLES=2, instance 1 uses WAIT_CYCLES=0.
// Directed transactions with hand-computed expected data, latency and error flags.
// Define DMEM_STATS_EN to also check the access counters on instance 1.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic [3:0]  req_be     [2];
    logic        resp_valid [2];
    logic        resp_ready [2];
    logic [31:0] resp_rdata [2];
    logic        resp_err   [2];
`ifdef DMEM_STATS_EN
    logic [15:0] stat_loads  [2];
    logic [15:0] stat_stores [2];
    logic [15:0] stat_errs   [2];
`endif

    int n_pass;
    int n_total;

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[0]),
        .req_ready  (req_ready[0]),
        .req_we     (req_we[0]),
        .req_addr   (req_addr[0]),
        .req_wdata  (req_wdata[0]),
        .req_be     (req_be[0]),
        .resp_valid (resp_valid[0]),
        .resp_ready (resp_ready[0]),
        .resp_rdata (resp_rdata[0]),
        .resp_err   (resp_err[0])
`ifdef DMEM_STATS_EN
        ,
        .stat_loads (stat_loads[0]),
        .stat_stores(stat_stores[0]),
        .stat_errs  (stat_errs[0])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid[1]),
        .req_ready  (req_ready[1]),
        .req_we     (req_we[1]),
        .req_addr   (req_addr[1]),
        .req_wdata  (req_wdata[1]),
        .req_be     (req_be[1]),
        .resp_valid (resp_valid[1]),
        .resp_ready (resp_ready[1]),
        .resp_rdata (resp_rdata[1]),
        .resp_err   (resp_err[1])
`ifdef DMEM_STATS_EN
        ,
        .stat_loads (stat_loads[1]),
        .stat_stores(stat_stores[1]),
        .stat_errs  (stat_errs[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance d with resp_ready held high.
    // cyc = number of negedges after the accept edge until resp_valid is seen.
    task automatic txn(input int d, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output logic [31:0] rdata, output logic err, output int cyc);
        int guard;
        req_we[d]    = we;
        req_addr[d]  = addr;
        req_wdata[d] = wdata;
        req_be[d]    = be;
        req_valid[d] = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!req_ready[d] && guard < 40);
        if (!req_ready[d]) chk("req_ready_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1 req_valid[d] = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!resp_valid[d] && cyc < 40);
        if (!resp_valid[d]) chk("resp_valid_timeout", 32'd0, 32'd1);
        rdata = resp_rdata[d];
        err   = resp_err[d];
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          cyc;
    int          guard;

    initial begin
        n_pass  = 0;
        n_total = 0;
        for (int d = 0; d < 2; d++) begin
            req_valid[d]  = 1'b0;
            req_we[d]     = 1'b0;
            req_addr[d]   = 32'd0;
            req_wdata[d]  = 32'd0;
            req_be[d]     = 4'h0;
            resp_ready[d] = 1'b1;
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready",  {31'd0, req_ready[0]}, 32'd1);
        chk("rst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("rst_resp_rdata", resp_rdata[0], 32'd0);
        chk("rst_resp_err",   {31'd0, resp_err[0]}, 32'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Full-word store then load, WAIT_CYCLES=2
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, er, cyc);
        chk("st10_latency", 32'(cyc), 32'd3);
        chk("st10_err",     {31'd0, er}, 32'd0);
        chk("st10_rdata",   rd, 32'd0);
        chk("st10_idle_after", {31'd0, resp_valid[0]}, 32'd0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
        chk("ld10_rdata",   rd, 32'hDEADBEEF);
        chk("ld10_err",     {31'd0, er}, 32'd0);
        chk("ld10_latency", 32'(cyc), 32'd3);

        // Partial byte-enable store
        txn(0, 1'b1, 32'h20, 32'h11223344, 4'hF, rd, er, cyc);
        txn(0, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, rd, er, cyc);
        chk("be_store_err", {31'd0, er}, 32'd0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, cyc);
        chk("be_load_rdata", rd, 32'h11BB33DD);

        // be=0 store is a no-op
        txn(0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, rd, er, cyc);
        chk("be0_err", {31'd0, er}, 32'd0);
        txn(0, 1'b0, 32'h20, 32'h0, 4'h0, rd, er, cyc);
        chk("be0_load_rdata", rd, 32'h11BB33DD);

        // Error cases: misaligned load, out-of-range store must not alias word 0
        txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, rd, er, cyc);
        txn(0, 1'b0, 32'h13, 32'h0, 4'h0, rd, er, cyc);
        chk("mis_ld_err",   {31'd0, er}, 32'd1);
        chk("mis_ld_rdata", rd, 32'd0);
        txn(0, 1'b1, 32'h400, 32'h0BADBAD0, 4'hF, rd, er, cyc);
        chk("oor_st_err",   {31'd0, er}, 32'd1);
        chk("oor_st_rdata", rd, 32'd0);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, rd, er, cyc);
        chk("word0_kept",   rd, 32'hCAFEF00D);
        chk("word0_err",    {31'd0, er}, 32'd0);
        txn(0, 1'b0, 32'h3FC, 32'h0, 4'h0, rd, er, cyc);
        chk("last_word_err", {31'd0, er}, 32'd0);

        // Backpressure: hold resp_ready low during a load response
        resp_ready[0] = 1'b0;
        req_we[0]     = 1'b0;
        req_addr[0]   = 32'h10;
        req_valid[0]  = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!resp_valid[0] && guard < 40);
        chk("bp_resp_seen", {31'd0, resp_valid[0]}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                req_we[0]    = 1'b1;
                req_addr[0]  = 32'h10;
                req_wdata[0] = 32'h0;
                req_be[0]    = 4'hF;
                req_valid[0] = 1'b1;
            end else begin
                req_valid[0] = 1'b0;
            end
            @(negedge clk);
            chk("bp_valid",     {31'd0, resp_valid[0]}, 32'd1);
            chk("bp_rdata",     resp_rdata[0], 32'hDEADBEEF);
            chk("bp_req_ready", {31'd0, req_ready[0]}, 32'd0);
        end
        req_valid[0]  = 1'b0;
        resp_ready[0] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_done_valid",     {31'd0, resp_valid[0]}, 32'd0);
        chk("bp_done_rdata",     resp_rdata[0], 32'd0);
        chk("bp_done_req_ready", {31'd0, req_ready[0]}, 32'd1);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
        chk("bp_pulse_ignored", rd, 32'hDEADBEEF);

        // Reset while a store waits: store must be dropped
        txn(0, 1'b1, 32'h8, 32'h12345678, 4'hF, rd, er, cyc);
        req_we[0]    = 1'b1;
        req_addr[0]  = 32'h8;
        req_wdata[0] = 32'h00000055;
        req_be[0]    = 4'hF;
        req_valid[0] = 1'b1;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        chk("pre_rst_req_ready", {31'd0, req_ready[0]}, 32'd0);
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("midrst_resp_valid", {31'd0, resp_valid[0]}, 32'd0);
        chk("midrst_req_ready",  {31'd0, req_ready[0]}, 32'd1);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        txn(0, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, cyc);
        chk("midrst_old_data", rd, 32'h12345678);

        // WAIT_CYCLES=0 instance: 2 stores, 3 loads, 1 misaligned access
        txn(1, 1'b1, 32'h4, 32'hA5A5A5A5, 4'hF, rd, er, cyc);
        chk("w0_st_latency", 32'(cyc), 32'd1);
        txn(1, 1'b1, 32'h8, 32'h5A5A5A5A, 4'hF, rd, er, cyc);
        txn(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, cyc);
        chk("w0_ld4_rdata",   rd, 32'hA5A5A5A5);
        chk("w0_ld_latency",  32'(cyc), 32'd1);
        txn(1, 1'b0, 32'h8, 32'h0, 4'h0, rd, er, cyc);
        chk("w0_ld8_rdata",   rd, 32'h5A5A5A5A);
        txn(1, 1'b0, 32'h4, 32'h0, 4'h0, rd, er, cyc);
        chk("w0_ld4b_rdata",  rd, 32'hA5A5A5A5);
        txn(1, 1'b0, 32'h6, 32'h0, 4'h0, rd, er, cyc);
        chk("w0_mis_err",     {31'd0, er}, 32'd1);
        chk("w0_mis_rdata",   rd, 32'd0);
`ifdef DMEM_STATS_EN
        chk("stat_loads",  {16'd0, stat_loads[1]},  32'd3);
        chk("stat_stores", {16'd0, stat_stores[1]}, 32'd2);
        chk("stat_errs",   {16'd0, stat_errs[1]},   32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Multi-cycle data-memory target answering load/store requests from the core's data-side initiator.
- Uses a valid/ready request channel and a valid/ready response channel.
- Adds programmable wait states, byte-enabled writes and address error reporting.
- Replaces the zero-latency data memory so the processor and future pipelined cores can be exercised against realistic memory timing.

Parameters:
- DEPTH_WORDS, 256, number of 32-bit words in storage; word index = req_addr[31:2].
- WAIT_CYCLES, 2, wait states between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  initiator presents a request.
- req_ready  output  1  responder can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data.
- req_be  input  4  byte enables for stores; bit i enables byte lane [8i+7:8i]; ignored for loads.
- resp_valid  output  1  response available.
- resp_ready  input  1  initiator accepts the response.
- resp_rdata  output  32  load data; 0 for stores and errors.
- resp_err  output  1  request was misaligned or out of range.

Behaviour:
- Reset (async, active-high) sets:
  - state = IDLE
  - req_ready = 1
  - resp_valid = 0
  - resp_rdata = 0
  - resp_err = 0
  - wait counter = 0
- Storage array is not reset; contents survive reset.
- States: IDLE, WAIT, RESP. Encoded FSM, registered outputs.
- IDLE:
  - req_ready = 1.
  - On an edge with req_valid = 1, capture we, addr, wdata and be into internal registers.
  - If WAIT_CYCLES > 0: go to WAIT with counter = WAIT_CYCLES.
  - If WAIT_CYCLES = 0: perform the access and go to RESP.
- WAIT:
  - req_ready = 0.
  - Counter decrements each edge.
  - On the edge where counter = 1, perform the access and go to RESP.
- Access (single edge):
  - Error if addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS. On error: no storage change, resp_err = 1, resp_rdata = 0.
  - Store: each byte lane with be[i] = 1 is written; resp_rdata = 0, resp_err = 0. be = 0 is a legal no-op store.
  - Load: resp_rdata = mem[addr[31:2]], resp_err = 0.
- RESP:
  - resp_valid = 1; resp_rdata and resp_err are held stable.
  - req_ready = 0.
  - On an edge with resp_ready = 1, clear resp_valid, resp_rdata and resp_err to 0 and return to IDLE.
  - A new request may be accepted on the first IDLE cycle after that edge; there is no back-to-back overlap.
- Latency: request accepted at edge N gives resp_valid high in the cycle after edge N+WAIT_CYCLES. With WAIT_CYCLES = 0, resp_valid is high in the cycle after acceptance.
- Backpressure: resp_ready may stay low indefinitely. The response must hold, and no further request is accepted meanwhile.
- Request signals are sampled only at the acceptance edge; later changes on req_* are ignored until the next IDLE.
- Reset mid-operation:
  - In WAIT: the pending store is dropped (storage unchanged).
  - In RESP: the response is discarded.
  - Either way, outputs return to their reset values asynchronously.
- Read-after-write to the same word in consecutive transactions returns the newly written data.

Optional Feature:
- Macro DMEM_STATS_EN.
- When defined, adds three outputs, each 16-bit and saturating at 16'hFFFF:
  - stat_loads: counts successful load accesses.
  - stat_stores: counts successful store accesses.
  - stat_errs: counts error accesses.
- Each counter increments on the access edge; all three clear to 0 on reset.
- When undefined, these ports and their logic are absent and behaviour is otherwise identical.

Test Plan:
- WAIT_CYCLES = 2: store addr 0x10, wdata 0xDEADBEEF, be 4'hF, resp_ready = 1 → resp_valid high in the cycle after edge N+2 with err = 0, rdata = 0. Then a load of 0x10 → rdata 0xDEADBEEF.
- Byte enables: word 0x20 preloaded 0x11223344; store wdata 0xAABBCCDD with be 4'b0101 → subsequent load returns 0x11BB33DD.
- Errors: load 0x13 → err = 1, rdata = 0. Store 0x400 with DEPTH_WORDS = 256 → err = 1, and a load of word 0 still returns its prior value.
- Backpressure: hold resp_ready = 0 for 10 cycles during a load response → resp_valid and rdata stay stable, req_ready = 0 throughout, a req_valid pulse is ignored, and the response completes once resp_ready = 1.
- Reset mid-WAIT: assert reset one cycle after accepting a store of 0x55 to 0x8 → resp_valid = 0 immediately; a load of 0x8 after reset returns the old contents.
- WAIT_CYCLES = 0 with DMEM_STATS_EN: 3 loads, 2 stores, 1 misaligned access, each responding one cycle after acceptance → stat_loads = 3, stat_stores = 2, stat_errs = 1.
